icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 RST  input  1  reset, synchronous, active-high.
REQ-003 dp_iREN  input  1  datapath instruction-read request (the decoder's iREN).
REQ-004 dp_iaddr  input  32  requested instruction byte address (PC), word-aligned.
REQ-005 dp_halt  input  1  datapath halted; no new fills are started.
REQ-006 flush  input  1  invalidate all frames.
REQ-007 dp_ihit  output  1  dp_iload valid this cycle for dp_iaddr.
REQ-008 dp_iload  output  32  instruction word returned to datapath.
REQ-009 mem_iREN  output  1  memory read request.
REQ-010 mem_iaddr  output  32  memory read address.
REQ-011 mem_iwait  input  1  memory busy; data not yet valid.
REQ-012 mem_iload  input  32  memory read data, valid when mem_iREN=1 and mem_iwait=0.

Function
REQ-013 Direct-mapped: 16 frames, one 32-bit word per frame; address split tag[31:6], index[5:2], byte offset[1:0] (ignored).
REQ-014 Each frame holds valid (1), tag (26), data (32).
REQ-015 FSM states: IDLE, FILL.
REQ-016 IDLE, hit (dp_iREN=1, frame valid, tag match, flush=0): dp_ihit=1 and dp_iload=frame data combinationally, same cycle; state stays IDLE.
REQ-017 IDLE, miss with dp_iREN=1, dp_halt=0, flush=0: dp_ihit=0; latch dp_iaddr into fill address; next state FILL.
REQ-018 IDLE with dp_halt=1 or dp_iREN=0: no state change, dp_ihit=0 unless REQ-016 hit applies.
REQ-019 FILL: mem_iREN=1, mem_iaddr=latched fill address, held constant until completion.
REQ-020 FILL, mem_iwait=1: remain FILL, dp_ihit=0.
REQ-021 FILL, mem_iwait=0: write mem_iload and tag to the indexed frame, set valid, return to IDLE next edge.
REQ-022 Completion forwarding: in the completion cycle, dp_ihit=1 and dp_iload=mem_iload only if dp_iREN=1 and dp_iaddr equals the fill address; otherwise dp_ihit=0.
REQ-023 If dp_iaddr changes during FILL (redirect), the fill is not aborted; it completes per REQ-021, and the new address is looked up from IDLE.
REQ-024 Fill latency: miss seen in cycle N, mem_iREN from N+1; hit/forward no earlier than N+1.
REQ-025 flush=1 in IDLE: all valid bits cleared at next edge; dp_ihit=0 that cycle; no fill started.
REQ-026 flush=1 in FILL: fill continues; on completion data and tag are written but valid is not set; all other valids are cleared; dp_ihit=0 in any flush cycle.
REQ-027 When mem_iREN=0, mem_iaddr=0.
REQ-028 When dp_ihit=0, dp_iload=0.

Reset
REQ-029 RST=1 at an edge: state=IDLE, all valid bits=0; tags/data need not be cleared.
REQ-030 While RST=1 and after: dp_ihit=0, dp_iload=0, mem_iREN=0, mem_iaddr=0 until a new request.
REQ-031 RST during FILL abandons the fill: mem_iREN=0 from the next edge; no frame is written.

Structure
REQ-032 icache_frame_t (valid, tag, data) and constants ICACHE_FRAMES=16, ICACHE_TAG_W=26, ICACHE_IDX_W=4 belong in cpu_types_pkg.
REQ-033 State enum icache_state_t (IDLE, FILL) belongs in cpu_types_pkg.
REQ-034 Single module; no sub-module required.

Verification
REQ-035 Cold miss: RST, then dp_iREN=1, dp_iaddr=0x0000_0040, mem_iwait=1 for 3 cycles then 0 with mem_iload=0x3C01_0001 -> mem_iREN=1 with mem_iaddr=0x40 for 4 cycles, dp_ihit=1 and dp_iload=0x3C01_0001 in the completion cycle.
REQ-036 Re-access 0x40 next cycle -> dp_ihit=1 same cycle, mem_iREN=0.
REQ-037 Conflict: fill 0x40, then access 0x80 (same index 0, different tag) -> miss and refill; access 0x40 again -> miss.
REQ-038 Redirect: miss on 0x100, change dp_iaddr to 0x104 mid-fill -> fill of 0x100 completes with dp_ihit=0, then 0x104 misses; later 0x100 hits.
REQ-039 Flush: fill 0x40, assert flush one cycle -> next access to 0x40 misses; flush during a fill -> that frame is not valid afterward.
REQ-040 Halt and reset: dp_halt=1 with a miss -> mem_iREN stays 0; RST in third FILL cycle -> mem_iREN=0 next cycle and 0x40 misses afterward.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the instruction cache.
//   ICACHE_FRAMES / ICACHE_TAG_W / ICACHE_IDX_W : cache geometry
//   ICACHE_IDX_LSB / ICACHE_TAG_LSB             : address field positions
//   icache_frame_t                              : one direct-mapped frame
//   icache_state_t                              : cache controller states
package cpu_types_pkg;

    localparam int ICACHE_FRAMES  = 16;
    localparam int ICACHE_TAG_W   = 26;
    localparam int ICACHE_IDX_W   = 4;
    localparam int ICACHE_IDX_LSB = 2;
    localparam int ICACHE_TAG_LSB = ICACHE_IDX_LSB + ICACHE_IDX_W;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Datapath-side and memory-side signals of the instruction cache.
//   slave  : the cache's view (takes requests, returns words, drives memory reads)
//   master : the environment's view (datapath + instruction memory)
// Signals:
//   dp_iREN, dp_iaddr, dp_halt, flush : datapath request / control
//   dp_ihit, dp_iload                 : cache reply to datapath
//   mem_iREN, mem_iaddr               : memory read request
//   mem_iwait, mem_iload              : memory reply
interface icache_if;
    logic        dp_iREN;
    logic [31:0] dp_iaddr;
    logic        dp_halt;
    logic        flush;
    logic        dp_ihit;
    logic [31:0] dp_iload;
    logic        mem_iREN;
    logic [31:0] mem_iaddr;
    logic        mem_iwait;
    logic [31:0] mem_iload;

    modport slave (
        input  dp_iREN, dp_iaddr, dp_halt, flush, mem_iwait, mem_iload,
        output dp_ihit, dp_iload, mem_iREN, mem_iaddr
    );

    modport master (
        output dp_iREN, dp_iaddr, dp_halt, flush, mem_iwait, mem_iload,
        input  dp_ihit, dp_iload, mem_iREN, mem_iaddr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache: 16 one-word frames, blocking single fill.
// Ports:
//   CLK  : clock, all state on the rising edge
//   RST  : synchronous active-high reset (clears valid bits, abandons a fill)
//   bus  : icache_if.slave carrying the datapath and memory signals
// A hit in IDLE is answered combinationally. A miss latches the address and
// moves to FILL, which holds the memory request until mem_iwait drops; the
// returned word is written into its frame and forwarded if still requested.
module icache
    import cpu_types_pkg::*;
(
    input  logic    CLK,
    input  logic    RST,
    icache_if.slave bus
);

    icache_frame_t           frames [ICACHE_FRAMES];
    icache_state_t           state;
    icache_state_t           state_next;
    logic [31:0]             fill_addr;
    logic                    fill_flushed;
    logic [ICACHE_IDX_W-1:0] lookup_idx;
    logic [ICACHE_IDX_W-1:0] fill_idx;
    logic                    lookup_hit;
    logic                    start_fill;
    logic                    fill_done;
    logic                    fill_valid;

    assign lookup_idx = bus.dp_iaddr[ICACHE_IDX_LSB +: ICACHE_IDX_W];
    assign fill_idx   = fill_addr[ICACHE_IDX_LSB +: ICACHE_IDX_W];
    assign lookup_hit = frames[lookup_idx].valid &&
                        (frames[lookup_idx].tag == bus.dp_iaddr[31:ICACHE_TAG_LSB]);

    // All outputs are forced quiet while RST is high, whatever the state.
    always_comb begin
        state_next    = state;
        start_fill    = 1'b0;
        fill_done     = 1'b0;
        fill_valid    = 1'b0;
        bus.dp_ihit   = 1'b0;
        bus.dp_iload  = '0;
        bus.mem_iREN  = 1'b0;
        bus.mem_iaddr = '0;
        if (!RST) begin
            case (state)
                IDLE: begin
                    if (bus.dp_iREN && !bus.flush) begin
                        if (lookup_hit) begin
                            bus.dp_ihit  = 1'b1;
                            bus.dp_iload = frames[lookup_idx].data;
                        end else if (!bus.dp_halt) begin
                            start_fill = 1'b1;
                            state_next = FILL;
                        end
                    end
                end
                FILL: begin
                    bus.mem_iREN  = 1'b1;
                    bus.mem_iaddr = fill_addr;
                    if (!bus.mem_iwait) begin
                        fill_done  = 1'b1;
                        // A flush anywhere in the fill makes the word stale.
                        fill_valid = !(bus.flush || fill_flushed);
                        state_next = IDLE;
                        if (bus.dp_iREN && !bus.flush && (bus.dp_iaddr == fill_addr)) begin
                            bus.dp_ihit  = 1'b1;
                            bus.dp_iload = bus.mem_iload;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Tag/data and the fill address are never reset; only valid bits and
    // control state are.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            fill_flushed <= 1'b0;
            for (int i = 0; i < ICACHE_FRAMES; i++) begin
                frames[i].valid <= 1'b0;
            end
        end else begin
            state <= state_next;
            if (start_fill) begin
                fill_addr    <= bus.dp_iaddr;
                fill_flushed <= 1'b0;
            end else if (state == FILL && bus.flush) begin
                fill_flushed <= 1'b1;
            end
            if (bus.flush) begin
                for (int i = 0; i < ICACHE_FRAMES; i++) begin
                    frames[i].valid <= 1'b0;
                end
            end
            // Placed after the flush clear so the completing frame's own
            // valid value wins on that index.
            if (fill_done) begin
                frames[fill_idx] <= '{valid: fill_valid,
                                      tag:   fill_addr[31:ICACHE_TAG_LSB],
                                      data:  bus.mem_iload};
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a word-address-level cache model checked
// every cycle, plus hand-computed literal expectations on directed scenarios.
module tb_icache;

    logic CLK = 1'b0;
    logic RST;
    bit   started = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    icache_if bus ();

    icache dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: each slot remembers which word address it holds.
    bit          mv [16];
    logic [31:0] ma [16];
    logic [31:0] md [16];
    bit          m_fill;
    bit          m_fflush;
    logic [31:0] m_faddr;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_ren;
    logic [31:0] e_maddr;
    int          slot;

    always @(negedge CLK) begin
        if (started) begin
            e_hit = 1'b0; e_load = '0; e_ren = 1'b0; e_maddr = '0;
            if (RST) begin
                m_fill = 1'b0;
                for (int k = 0; k < 16; k++) mv[k] = 1'b0;
            end else if (!m_fill) begin
                slot = int'((bus.dp_iaddr >> 2) % 32'd16);
                if (bus.dp_iREN && !bus.flush && mv[slot] && ma[slot][31:2] == bus.dp_iaddr[31:2]) begin
                    e_hit = 1'b1;
                    e_load = md[slot];
                end else if (bus.dp_iREN && !bus.flush && !bus.dp_halt) begin
                    m_fill = 1'b1; m_fflush = 1'b0; m_faddr = bus.dp_iaddr;
                end
                if (bus.flush) for (int k = 0; k < 16; k++) mv[k] = 1'b0;
            end else begin
                e_ren = 1'b1;
                e_maddr = m_faddr;
                if (bus.flush) for (int k = 0; k < 16; k++) mv[k] = 1'b0;
                if (!bus.mem_iwait) begin
                    slot = int'((m_faddr >> 2) % 32'd16);
                    mv[slot] = !(bus.flush || m_fflush);
                    ma[slot] = m_faddr;
                    md[slot] = bus.mem_iload;
                    m_fill = 1'b0;
                    if (bus.dp_iREN && !bus.flush && bus.dp_iaddr == m_faddr) begin
                        e_hit = 1'b1;
                        e_load = bus.mem_iload;
                    end
                end else begin
                    m_fflush = m_fflush || bus.flush;
                end
            end
            chk("dp_ihit",   32'(bus.dp_ihit),  32'(e_hit));
            chk("dp_iload",  bus.dp_iload,      e_load);
            chk("mem_iREN",  32'(bus.mem_iREN), 32'(e_ren));
            chk("mem_iaddr", bus.mem_iaddr,     e_maddr);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
        #1;
    endtask

    // Miss cycle (current cycle), `waits` busy cycles, then completion.
    task automatic fill(input logic [31:0] a, input int waits, input logic [31:0] d);
        bus.dp_iREN = 1'b1; bus.dp_iaddr = a; bus.mem_iwait = 1'b1;
        tick();
        repeat (waits) tick();
        bus.mem_iwait = 1'b0; bus.mem_iload = d;
        tick();
        bus.mem_iwait = 1'b1; bus.mem_iload = '0;
    endtask

    initial begin
        RST = 1'b1;
        bus.dp_iREN = 1'b0; bus.dp_iaddr = '0; bus.dp_halt = 1'b0; bus.flush = 1'b0;
        bus.mem_iwait = 1'b1; bus.mem_iload = '0;
        started = 1'b1;
        tick();
        mid();
        chk("rst_ihit",  32'(bus.dp_ihit),  32'h0);
        chk("rst_iload", bus.dp_iload,      32'h0);
        chk("rst_mren",  32'(bus.mem_iREN), 32'h0);
        chk("rst_maddr", bus.mem_iaddr,     32'h0);
        tick();

        // Cold miss on 0x40 with three busy cycles.
        RST = 1'b0; bus.dp_iREN = 1'b1; bus.dp_iaddr = 32'h40;
        mid();
        chk("cold_miss_ren", 32'(bus.mem_iREN), 32'h0);
        tick();
        for (int c = 0; c < 3; c++) begin
            mid();
            chk("cold_fill_ren",  32'(bus.mem_iREN), 32'h1);
            chk("cold_fill_addr", bus.mem_iaddr,     32'h40);
            chk("cold_fill_hit",  32'(bus.dp_ihit),  32'h0);
            tick();
        end
        bus.mem_iwait = 1'b0; bus.mem_iload = 32'h3C01_0001;
        mid();
        chk("cold_done_ren",  32'(bus.mem_iREN), 32'h1);
        chk("cold_fwd_hit",   32'(bus.dp_ihit),  32'h1);
        chk("cold_fwd_load",  bus.dp_iload,      32'h3C01_0001);
        tick();
        bus.mem_iwait = 1'b1; bus.mem_iload = '0;
        mid();
        chk("reaccess_hit",  32'(bus.dp_ihit),  32'h1);
        chk("reaccess_load", bus.dp_iload,      32'h3C01_0001);
        chk("reaccess_ren",  32'(bus.mem_iREN), 32'h0);
        tick();

        // Conflict on index 0.
        fill(32'h80, 1, 32'hAAAA_0080);
        bus.dp_iaddr = 32'h40;
        mid();
        chk("conflict_miss", 32'(bus.dp_ihit), 32'h0);
        fill(32'h40, 0, 32'h3C01_0001);

        // Redirect mid-fill.
        bus.dp_iaddr = 32'h100;
        tick();
        tick();
        bus.dp_iaddr = 32'h104;
        tick();
        bus.mem_iwait = 1'b0; bus.mem_iload = 32'h1111_0100;
        mid();
        chk("redir_done_hit",  32'(bus.dp_ihit), 32'h0);
        chk("redir_done_addr", bus.mem_iaddr,    32'h100);
        tick();
        bus.mem_iwait = 1'b1; bus.mem_iload = '0;
        mid();
        chk("redir_new_miss", 32'(bus.dp_ihit),  32'h0);
        chk("redir_new_ren",  32'(bus.mem_iREN), 32'h0);
        fill(32'h104, 0, 32'h2222_0104);
        bus.dp_iaddr = 32'h100;
        mid();
        chk("redir_old_hit",  32'(bus.dp_ihit), 32'h1);
        chk("redir_old_load", bus.dp_iload,     32'h1111_0100);
        tick();

        // Flush in IDLE, then flush during a fill.
        fill(32'h40, 1, 32'h3C01_0001);
        mid();
        chk("pre_flush_hit", 32'(bus.dp_ihit), 32'h1);
        tick();
        bus.flush = 1'b1;
        mid();
        chk("flush_cyc_hit", 32'(bus.dp_ihit),  32'h0);
        chk("flush_cyc_ren", 32'(bus.mem_iREN), 32'h0);
        tick();
        bus.flush = 1'b0;
        mid();
        chk("post_flush_miss", 32'(bus.dp_ihit), 32'h0);
        fill(32'h40, 0, 32'h3C01_0001);
        bus.dp_iaddr = 32'h48;
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.mem_iwait = 1'b0; bus.mem_iload = 32'h4848_4848;
        mid();
        chk("flushfill_fwd", 32'(bus.dp_ihit), 32'h1);
        tick();
        bus.mem_iwait = 1'b1; bus.mem_iload = '0;
        mid();
        chk("flushfill_invalid", 32'(bus.dp_ihit), 32'h0);
        fill(32'h48, 0, 32'h4848_4848);
        bus.dp_iaddr = 32'h40;
        mid();
        chk("flushfill_other_inv", 32'(bus.dp_ihit), 32'h0);
        fill(32'h40, 0, 32'h3C01_0001);

        // Halt blocks a miss from starting a fill.
        bus.dp_iaddr = 32'h200; bus.dp_halt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk("halt_ren", 32'(bus.mem_iREN), 32'h0);
            chk("halt_hit", 32'(bus.dp_ihit),  32'h0);
            tick();
        end
        bus.dp_halt = 1'b0;
        fill(32'h200, 1, 32'h2002_0200);
        mid();
        chk("halt_after_hit", bus.dp_iload, 32'h2002_0200);
        tick();

        // Reset in the third FILL cycle.
        fill(32'h40, 0, 32'h3C01_0001);
        mid();
        chk("prerst_hit", 32'(bus.dp_ihit), 32'h1);
        tick();
        bus.dp_iaddr = 32'h80;
        tick();
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; bus.dp_iREN = 1'b0;
        mid();
        chk("rstfill_ren",   32'(bus.mem_iREN), 32'h0);
        chk("rstfill_maddr", bus.mem_iaddr,     32'h0);
        tick();
        bus.dp_iREN = 1'b1; bus.dp_iaddr = 32'h40;
        mid();
        chk("rstfill_miss", 32'(bus.dp_ihit), 32'h0);
        fill(32'h40, 0, 32'h3C01_0001);
        bus.dp_iREN = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
